// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
//
// The main register drives out_*. The skid register catches the one entry that can
// arrive in the cycle the downstream stalls, so in_ready depends only on local state
// and never on out_ready. The control vector is forced to zero whenever no valid
// entry is presented (a bubble). The payload is optionally cleared on flush.
// A saturating counter records cycles spent stalled by the downstream stage.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         synchronous squash of all held entries
//   in_valid      upstream offers an entry
//   in_ready      stage can accept (registered, state-only)
//   in_ctrl       upstream control vector
//   in_data       upstream payload
//   out_valid     main entry valid (registered)
//   out_ready     downstream accepts
//   out_ctrl      main entry control, zero whenever out_valid=0
//   out_data      main entry payload
//   occupancy     number of entries held (0, 1, 2)
//   stall_cnt     saturating count of cycles with out_valid=1 and out_ready=0
//   stall_clr     synchronous clear of stall_cnt
module pipe_stage_skid_reg #(
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned DATA_W     = 108,
    parameter bit          CLEAR_DATA = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic skid_valid;
    logic in_fire;
    logic out_fire;

    // All handshake outputs decode straight from flops.
    assign skid_valid = (state_q == StFull);
    assign in_ready   = !skid_valid;
    assign out_valid  = (state_q != StEmpty);
    assign occupancy  = state_q;
    assign out_ctrl   = main_ctrl_q;
    assign out_data   = main_data_q;
    assign stall_cnt  = cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Any in_fire this cycle is dropped; an out_fire is simply a normal consume.
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d     = StBusy;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                StBusy: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        state_d     = StFull;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        // Drain to a bubble; payload is left as-is.
                        state_d     = StEmpty;
                        main_ctrl_d = '0;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_d     = StBusy;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = StEmpty;
                    main_ctrl_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg. Two instances share stimulus: dut (CLEAR_DATA=1,
// CNT_W=4) and dut_nc (CLEAR_DATA=0, default CNT_W). Accepted entries are queued
// by the stimulus side; a monitor pops and compares on every out_fire of dut.
module tb_pipe_stage_skid_reg;

    localparam int CW = 16;
    localparam int DW = 108;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [3:0]    stall_cnt;
    logic          stall_clr;

    logic          nc_in_ready;
    logic          nc_out_valid;
    logic [CW-1:0] nc_out_ctrl;
    logic [DW-1:0] nc_out_data;
    logic [1:0]    nc_occupancy;
    logic [15:0]   nc_stall_cnt;

    int total = 0;
    int bad   = 0;
    int popped = 0;

    logic [CW+DW-1:0] exp_q[$];
    logic [CW+DW-1:0] exp_e;

    pipe_stage_skid_reg #(
        .CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt),
        .stall_clr(stall_clr)
    );

    pipe_stage_skid_reg #(
        .CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0), .CNT_W(16)
    ) dut_nc (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(nc_out_valid), .out_ready(out_ready), .out_ctrl(nc_out_ctrl),
        .out_data(nc_out_data), .occupancy(nc_occupancy), .stall_cnt(nc_stall_cnt),
        .stall_clr(stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record an accepted entry just before the edge that takes it, then settle past the edge.
    task automatic step();
        @(negedge clk);
        if (!rst && !flush && in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [11:0] v);
        in_valid = 1'b1;
        in_ctrl  = {4'h8, v};
        in_data  = {96'd0, v};
    endtask

    // Monitor: compares every consumed entry against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h expected none", {out_ctrl, out_data});
                end else begin
                    exp_e = exp_q.pop_front();
                    check("out_entry", {out_ctrl, out_data}, exp_e);
                    popped++;
                end
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b1; stall_clr = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            offer(12'(i));
            step();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, i);
            check("stream_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_ctrl", out_ctrl, 0);
        check("drain_data_held", out_data, 8);
        check("drain_occ", occupancy, 0);
        check("stream_stall", stall_cnt, 0);

        // Back-pressure for three cycles.
        offer(12'h011);
        step();
        out_ready = 1'b0;
        offer(12'h012);
        step();
        check("bp_in_ready", in_ready, 0);
        check("bp_occ", occupancy, 2);
        check("bp_data", out_data, 12'h011);
        offer(12'h013);
        step();
        step();
        check("bp_stall3", stall_cnt, 3);
        check("bp_still_full", occupancy, 2);
        out_ready = 1'b1;
        step();
        check("bp_promote_ready", in_ready, 1);
        check("bp_promote_data", out_data, 12'h012);
        check("bp_promote_occ", occupancy, 1);
        step();
        check("bp_next_data", out_data, 12'h013);
        in_valid = 1'b0;
        step();
        check("bp_empty", occupancy, 0);
        check("bp_stall_kept", stall_cnt, 3);

        // Flush from FULL with an offered entry.
        offer(12'h021);
        step();
        out_ready = 1'b0;
        offer(12'h022);
        step();
        check("pre_flush_occ", occupancy, 2);
        offer(12'h023);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_ctrl", out_ctrl, 0);
        check("flush_occ", occupancy, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_data_clr", out_data, 0);
        check("flush_nc_data", nc_out_data, 12'h021);
        check("flush_stall", stall_cnt, 5);

        // Flush from BUSY: payload held only in the CLEAR_DATA=0 build.
        out_ready = 1'b1;
        offer(12'hABC);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("nc_flush_valid", nc_out_valid, 0);
        check("nc_flush_ctrl", nc_out_ctrl, 0);
        check("nc_flush_data", nc_out_data, 12'hABC);
        check("cd_flush_data", out_data, 0);

        // out_fire in the flush cycle still consumes the entry.
        out_ready = 1'b1;
        offer(12'h031);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_fire_occ", occupancy, 0);
        check("flush_fire_stall", stall_cnt, 6);

        // Counter clear and saturation (CNT_W=4).
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        check("clr_stall", stall_cnt, 0);
        offer(12'h041);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check("sat_14", stall_cnt, 14);
        end
        check("sat_15", stall_cnt, 15);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        check("clr_over_incr", stall_cnt, 0);
        step();
        check("incr_after_clr", stall_cnt, 1);
        out_ready = 1'b1;
        step();
        check("sat_drain_occ", occupancy, 0);
        check("sat_drain_stall", stall_cnt, 1);

        // Asynchronous reset between edges while FULL.
        offer(12'h051);
        step();
        out_ready = 1'b0;
        offer(12'h052);
        step();
        check("pre_rst_occ", occupancy, 2);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ctrl", out_ctrl, 0);
        check("arst_data", out_data, 0);
        check("arst_occ", occupancy, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_stall", stall_cnt, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        offer(12'h061);
        step();
        check("resume_data0", out_data, 12'h061);
        check("resume_valid", out_valid, 1);
        offer(12'h062);
        step();
        check("resume_data1", out_data, 12'h062);
        in_valid = 1'b0;
        repeat (3) step();
        check("final_occ", occupancy, 0);
        check("queue_empty", exp_q.size(), 0);
        check("pop_count", popped, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
